// File: rtl/eq_coef_pkg.sv
// rtl/eq_coef_pkg.sv - shared defaults and FSM state type for the coefficient RAM controller
//
// Purpose: single home for the coefficient RAM geometry defaults and the
// controller state encoding, imported by every file of the block.
package eq_coef_pkg;

  localparam int COEF_ADDR_WIDTH = 4;
  localparam int COEF_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } coef_state_e;

endpackage

// File: rtl/coef_ram_ctrl_ram.sv
// rtl/coef_ram_ctrl_ram.sv - single-port coefficient RAM, async read, sync write
//
// Purpose: storage for the coefficient words. Contents are never reset.
// Ports:
//   clk_i    - clock, write happens on rising edge
//   we_i     - write enable
//   addr_i   - shared read/write address
//   wdata_i  - write data
//   rdata_o  - combinational read of mem[addr_i] (value before any same-cycle write)
module coef_ram_ctrl_ram
  import eq_coef_pkg::*;
#(
  parameter int ADDR_WIDTH = COEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = COEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/coef_ram_ctrl.sv
// rtl/coef_ram_ctrl.sv - arbitrates one coefficient RAM between config accesses and engine bursts
//
// Purpose: owns the coefficient RAM and grants at most one access per cycle.
// In IDLE every config request is granted. In BURST the engine reads one word
// per cycle; when the config side also requests, slots alternate, engine first.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cfg_req/we/addr/wdata          - config access request (held until granted)
//   cfg_gnt                        - combinational grant, high in the RAM-use cycle
//   cfg_rvalid/cfg_rdata           - registered ack + word read before any write
//   eng_start/eng_base/eng_len     - burst start pulse, first address, word count
//   eng_busy                       - burst in progress
//   eng_valid/eng_data/eng_idx     - registered burst word and its offset
//   eng_done                       - marks the final burst word
module coef_ram_ctrl
  import eq_coef_pkg::*;
#(
  parameter int ADDR_WIDTH = COEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = COEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_gnt,
  output logic                  cfg_rvalid,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  eng_start,
  input  logic [ADDR_WIDTH-1:0] eng_base,
  input  logic [ADDR_WIDTH:0]   eng_len,
  output logic                  eng_busy,
  output logic                  eng_valid,
  output logic [DATA_WIDTH-1:0] eng_data,
  output logic [ADDR_WIDTH-1:0] eng_idx,
  output logic                  eng_done
);

  coef_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  // 1: config side wins the next contended slot
  logic                  cfg_prio_q, cfg_prio_d;

  logic                  start_ok;
  logic                  last_slot;
  logic                  cfg_slot;
  logic                  eng_slot;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  cfg_rvalid_q;
  logic [DATA_WIDTH-1:0] cfg_rdata_q;
  logic                  eng_valid_q;
  logic [DATA_WIDTH-1:0] eng_data_q;
  logic [ADDR_WIDTH-1:0] eng_idx_q;
  logic                  eng_done_q;

  assign start_ok  = (state_q == ST_IDLE) && eng_start && (eng_len != '0);
  // offset is one bit narrower than len so a full-depth burst still compares correctly
  assign last_slot = (({1'b0, offset_q} + (ADDR_WIDTH + 1)'(1)) == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      offset_q     <= '0;
      len_q        <= '0;
      cfg_prio_q   <= 1'b0;
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
      eng_valid_q  <= 1'b0;
      eng_data_q   <= '0;
      eng_idx_q    <= '0;
      eng_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      len_q        <= len_d;
      cfg_prio_q   <= cfg_prio_d;
      cfg_rvalid_q <= cfg_slot;
      eng_valid_q  <= eng_slot;
      eng_done_q   <= eng_slot && last_slot;
      if (cfg_slot) begin
        cfg_rdata_q <= ram_rdata;
      end
      if (eng_slot) begin
        eng_data_q <= ram_rdata;
        eng_idx_q  <= offset_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    len_d      = len_q;
    cfg_prio_d = cfg_prio_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_BURST;
          base_d     = eng_base;
          len_d      = eng_len;
          offset_d   = '0;
          cfg_prio_d = 1'b0;
        end
      end
      ST_BURST: begin
        // pointer only moves on contended slots, so the first contention goes to the engine
        if (cfg_req) begin
          cfg_prio_d = eng_slot;
        end
        if (eng_slot) begin
          offset_d = offset_q + ADDR_WIDTH'(1);
          if (last_slot) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot arbitration (FSM outputs); no RAM access at all in a reset cycle
  always_comb begin
    cfg_slot = 1'b0;
    eng_slot = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        cfg_slot = cfg_req;
      end else begin
        cfg_slot = cfg_req && cfg_prio_q;
        eng_slot = !cfg_slot;
      end
    end
  end

  assign ram_we   = cfg_slot && cfg_we;
  assign ram_addr = cfg_slot ? cfg_addr : (base_q + offset_q);

  coef_ram_ctrl_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (cfg_wdata),
    .rdata_o (ram_rdata)
  );

  assign cfg_gnt    = cfg_slot;
  assign cfg_rvalid = cfg_rvalid_q;
  assign cfg_rdata  = cfg_rdata_q;
  assign eng_busy   = (state_q == ST_BURST);
  assign eng_valid  = eng_valid_q;
  assign eng_data   = eng_data_q;
  assign eng_idx    = eng_idx_q;
  assign eng_done   = eng_done_q;

endmodule

// File: doc/coef_ram_ctrl.md
COEF_RAM_CTRL -- requirements
Module: coef_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, coefficient RAM address width (depth = 2^ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 32, coefficient word width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port cfg_req  input  1  config-side (AXI4-Lite) access request; held until granted.
REQ-006 Port cfg_we  input  1  1 = write, 0 = read; valid while cfg_req is high.
REQ-007 Port cfg_addr  input  ADDR_WIDTH  config access address.
REQ-008 Port cfg_wdata  input  DATA_WIDTH  config write data.
REQ-009 Port cfg_gnt  output  1  combinational; high in the cycle the config access uses the RAM.
REQ-010 Port cfg_rvalid  output  1  registered; pulses one cycle after every grant.
REQ-011 Port cfg_rdata  output  DATA_WIDTH  registered; RAM word at cfg_addr before any write in the grant cycle.
REQ-012 Port eng_start  input  1  filter-engine burst start pulse.
REQ-013 Port eng_base  input  ADDR_WIDTH  first burst address, sampled on accepted start.
REQ-014 Port eng_len  input  ADDR_WIDTH+1  word count, 1..2^ADDR_WIDTH, sampled on accepted start.
REQ-015 Port eng_busy  output  1  high from the cycle after an accepted start until the cycle after the last read slot.
REQ-016 Port eng_valid  output  1  registered; one cycle after each engine read slot.
REQ-017 Port eng_data  output  DATA_WIDTH  registered coefficient word, qualified by eng_valid.
REQ-018 Port eng_idx  output  ADDR_WIDTH  registered burst offset (0..len-1) of eng_data.
REQ-019 Port eng_done  output  1  pulse coincident with eng_valid for the final word.

Function
REQ-020 Controller SHALL own the only RAM instance and perform at most one RAM access per cycle; RAM read is combinational, write on rising edge.
REQ-021 FSM states: IDLE, BURST; IDLE -> BURST on eng_start with eng_len != 0; BURST -> IDLE in the cycle the last engine read slot is issued.
REQ-022 eng_start in BURST, or with eng_len = 0, SHALL be ignored (no state change, no output).
REQ-023 IDLE: cfg_gnt = cfg_req every cycle (back-to-back config accesses allowed).
REQ-024 BURST, cfg_req low: engine reads one word per cycle.
REQ-025 BURST, cfg_req high: round-robin slot; after an engine slot the config side wins, after a config slot the engine wins; first contended slot after start goes to the engine.
REQ-026 Engine address = (base + offset) mod 2^ADDR_WIDTH; offset increments only on engine slots.
REQ-027 Config write to an address the engine has not yet read SHALL be visible to that later engine read; config read of an address written in an earlier cycle SHALL return the new value.
REQ-028 cfg_rvalid also pulses for writes (write acknowledge); cfg_rdata then carries the old word.
REQ-029 eng_valid-to-eng_valid gap SHALL never exceed 2 cycles in BURST.
REQ-030 Latency: start accepted cycle N -> first eng_valid at N+2 when uncontended (first read slot N+1).

Reset
REQ-031 rst high at a clock edge: state IDLE, offset 0, round-robin pointer = engine, all registered outputs (cfg_rvalid, cfg_rdata, eng_valid, eng_data, eng_idx, eng_done, eng_busy) = 0.
REQ-032 rst during BURST aborts the burst with no eng_done; RAM contents are not cleared; no write in a reset cycle.

Structure
REQ-033 Package eq_coef_pkg SHALL hold the ADDR_WIDTH/DATA_WIDTH defaults and the FSM state enum.
REQ-034 Single sub-module: the team's existing ram block (instance u_ram), addressed and write-enabled by a mux in coef_ram_ctrl.

Verification
REQ-035 Config write 0xA5A5_0001 @3, then read @3 -> gnt both cycles, second cfg_rvalid returns 0xA5A5_0001.
REQ-036 Preload addr i = i; start base 14, len 4, no cfg traffic -> eng_data 14,15,0,1, idx 0..3, eng_done with last word, contiguous valids.
REQ-037 Burst base 0, len 8 with cfg_req held high (8 reads) -> strict alternation, engine first, 16 slots, busy clears afterwards.
REQ-038 During burst base 0 len 16, config write 0xDEAD @10 granted before offset 10 -> eng_idx 10 returns 0xDEAD.
REQ-039 eng_start during BURST and eng_start with len 0 -> ignored, no extra valids.
REQ-040 rst at offset 5 of len-16 burst -> next cycle IDLE, eng_busy 0, no eng_done, RAM preload intact on readback.
